// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU present sequencer.
// Bus map, control-word layout and FSM states.
package gpu_pkg;

    localparam logic [7:0] GPU_ADDRESS = 8'h02;

    localparam logic [10:0] OFF_CTRL   = 11'd0;
    localparam logic [10:0] OFF_STATUS = 11'd2;
    localparam logic [10:0] OFF_CHAR   = 11'd4;
    localparam logic [10:0] OFF_END    = 11'd1204;

    localparam int CTRL_COPY     = 0;
    localparam int CTRL_BLANK    = 1;
    localparam int CTRL_MODE     = 2;
    localparam int CTRL_COLOR_LO = 3;
    localparam int CTRL_COLOR_HI = 14;

    localparam logic [10:0] CELL_COUNT = 11'd1200;

    typedef enum logic [1:0] {
        IDLE,
        CHAR_WR,
        CTRL_WR,
        POLL
    } state_e;

    typedef struct packed {
        logic [10:0] index;
        logic [63:0] data;
    } char_t;

    function automatic logic [63:0] bus_addr(
        input logic [7:0]  dev,
        input logic [10:0] off
    );
        return {dev, 45'b0, off};
    endfunction

endpackage

// File: rtl/gpu_present_sequencer_if.sv
// Character queue, request, GPU bus and status signals
// of the present sequencer.
interface gpu_present_sequencer_if;

    logic        charValid;
    logic        charReady;
    logic [10:0] charIndex;
    logic [63:0] charData;
    logic        presentReq;
    logic        clearReq;
    logic [11:0] color;
    logic        mode;
    logic [63:0] address;
    logic [63:0] dataOut;
    logic [63:0] dataIn;
    logic        read;
    logic        write;
    logic        busy;
    logic [1:0]  errors;

    modport slave (
        input  charValid, charIndex, charData,
        input  presentReq, clearReq, color, mode, dataIn,
        output charReady, address, dataOut, read, write,
        output busy, errors
    );

    modport master (
        output charValid, charIndex, charData,
        output presentReq, clearReq, color, mode, dataIn,
        input  charReady, address, dataOut, read, write,
        input  busy, errors
    );

endinterface

// File: rtl/gpu_char_fifo.sv
// Power-of-two FIFO holding pending character writes.
// Pointers carry one wrap bit to tell full from empty.
module gpu_char_fifo #(
    parameter int WIDTH = 75,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/gpu_present_sequencer.sv
// Drains queued character writes to the GPU, then runs
// clear/present control sequences with status polling.
module gpu_present_sequencer #(
    parameter logic [7:0] GPU_ADDRESS  = gpu_pkg::GPU_ADDRESS,
    parameter int         FIFO_DEPTH   = 8,
    parameter int         POLL_TIMEOUT = 4096
) (
    input  logic                    clock,
    input  logic                    resetN,
    gpu_present_sequencer_if.slave  bus
);

    import gpu_pkg::*;

    localparam logic [11:0] TO_LAST = 12'(POLL_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        clr_q, clr_d;
    logic        pre_q, pre_d;
    logic [11:0] cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] dout_q, dout_d;

    logic        accept, idx_ok, good;
    logic        push, pop, bypass;
    logic        start_clr, start_pre;
    logic        fifo_full, fifo_empty;
    logic        have_char;
    char_t       head, entry, incoming;
    logic [63:0] ctrl;

    assign incoming  = '{index: bus.charIndex, data: bus.charData};
    assign accept    = bus.charValid && !fifo_full;
    assign idx_ok    = bus.charIndex < CELL_COUNT;
    assign good      = accept && idx_ok;
    assign push      = good && !bypass;
    assign have_char = !fifo_empty || good;

    gpu_char_fifo #(
        .WIDTH ($bits(char_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (resetN),
        .push_i  (push),
        .din_i   (incoming),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Outputs are registered, so the next cycle's strobes are decided here;
    // an empty queue lets an incoming cell bypass straight to the bus.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q | bus.clearReq;
        pre_d     = pre_q | bus.presentReq;
        cnt_d     = cnt_q;
        err_d     = err_q;
        read_d    = 1'b0;
        write_d   = 1'b0;
        addr_d    = addr_q;
        dout_d    = dout_q;
        pop       = 1'b0;
        bypass    = 1'b0;
        start_clr = 1'b0;
        start_pre = 1'b0;
        entry     = fifo_empty ? incoming : head;
        ctrl      = '0;

        if (accept && !idx_ok) err_d[0] = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (have_char) begin
                    state_d = CHAR_WR;
                end else if (clr_q) begin
                    state_d   = CTRL_WR;
                    start_clr = 1'b1;
                end else if (pre_q) begin
                    state_d   = CTRL_WR;
                    start_pre = 1'b1;
                end
            end
            CHAR_WR: state_d = have_char ? CHAR_WR : IDLE;
            CTRL_WR: begin
                state_d = POLL;
                cnt_d   = '0;
            end
            POLL: begin
                if (bus.dataIn[1:0] == 2'b00) begin
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = IDLE;
                    err_d[1] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
        endcase

        if (state_d == CHAR_WR) begin
            write_d = 1'b1;
            pop     = !fifo_empty;
            bypass  = fifo_empty;
            addr_d  = bus_addr(GPU_ADDRESS, OFF_CHAR + entry.index);
            dout_d  = entry.data;
        end

        if (state_d == CTRL_WR) begin
            ctrl[CTRL_COLOR_HI:CTRL_COLOR_LO] = bus.color;
            ctrl[CTRL_MODE]  = bus.mode;
            ctrl[CTRL_BLANK] = start_clr;
            ctrl[CTRL_COPY]  = start_pre;
            write_d = 1'b1;
            addr_d  = bus_addr(GPU_ADDRESS, OFF_CTRL);
            dout_d  = ctrl;
        end

        if (state_d == POLL) begin
            read_d = 1'b1;
            addr_d = bus_addr(GPU_ADDRESS, OFF_CTRL);
        end

        if (start_clr) clr_d = 1'b0;
        if (start_pre) pre_d = 1'b0;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
            pre_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.charReady = !fifo_full;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.address   = addr_q;
    assign bus.dataOut   = dout_q;
    assign bus.errors    = err_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty ||
                           clr_q || pre_q;

endmodule

// File: tb/tb_gpu_present_sequencer.sv
// Bench for gpu_present_sequencer: directed scenarios plus a
// randomized run against a transaction-level GPU/queue model.
module tb_gpu_present_sequencer;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // GPU status model: control bits stay set for lat poll reads
    int   rem  = 0;
    int   lat  = 5;
    bit   hang = 1'b0;

    gpu_present_sequencer_if bif();

    gpu_present_sequencer dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bif)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bif.write && bif.address[10:0] == 11'd0) rem = lat;
        else if (bif.read && rem > 0) rem = rem - 1;
        bif.dataIn = (hang || rem != 0) ? 64'h1 : 64'h0;
    end

    function automatic logic [63:0] cell_addr(input logic [10:0] idx);
        logic [10:0] off;
        off = idx + 11'd4;
        return {8'h02, 45'b0, off};
    endfunction

    function automatic logic [63:0] ctrl_word(input logic [11:0] c,
                                              input logic m,
                                              input logic [1:0] code);
        return (64'(c) << 3) | (64'(m) << 2) | 64'(code);
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bif.charValid  = 1'b0;
        bif.presentReq = 1'b0;
        bif.clearReq   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bif.charIndex = '0;
        bif.charData  = '0;
        bif.color     = '0;
        bif.mode      = 1'b0;
        resetN = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bif.read !== 1'b0 || bif.write !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_strobes got r%b w%b want 0 0", bif.read, bif.write);
        end
        n_checks++;
        if (bif.address !== 64'h0 || bif.dataOut !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_bus got a%h d%h want 0", bif.address, bif.dataOut);
        end
        n_checks++;
        if (bif.busy !== 1'b0 || bif.charReady !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_flow got busy%b rdy%b want 0 1", bif.busy, bif.charReady);
        end
        n_checks++;
        if (bif.errors !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_errors got %b want 00", bif.errors);
        end
        next_cycle();
        resetN = 1'b1;
    endtask

    task automatic test_single_char();
        next_cycle();
        bif.charValid = 1'b1;
        bif.charIndex = 11'd0;
        bif.charData  = 64'h41;
        @(negedge clock);
        next_cycle();
        bif.charValid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bif.write !== 1'b1 || bif.read !== 1'b0) begin
            n_errors++;
            $display("FAIL single_write got w%b r%b want 1 0", bif.write, bif.read);
        end
        n_checks++;
        if (bif.address !== 64'h0200_0000_0000_0004 || bif.dataOut !== 64'h41) begin
            n_errors++;
            $display("FAIL single_bus got a%h d%h want 0200000000000004 41",
                     bif.address, bif.dataOut);
        end
        next_cycle();
        @(negedge clock);
        n_checks++;
        if (bif.write !== 1'b0 || bif.address !== 64'h0200_0000_0000_0004 ||
            bif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_hold got w%b a%h busy%b want 0 0200000000000004 0",
                     bif.write, bif.address, bif.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] idx [9];
        logic [63:0] dat [9];
        for (int i = 0; i < 9; i++) begin
            idx[i] = 11'($urandom_range(0, 1199));
            dat[i] = {$urandom, $urandom};
        end
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            bif.charValid = (i < 9);
            if (i < 9) begin
                bif.charIndex = idx[i];
                bif.charData  = dat[i];
            end
            @(negedge clock);
            if (i < 9) begin
                n_checks++;
                if (bif.charReady !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_ready[%0d] got %b want 1", i, bif.charReady);
                end
            end
            if (i > 0 && i < 10) begin
                n_checks++;
                if (bif.write !== 1'b1 || bif.address !== cell_addr(idx[i-1]) ||
                    bif.dataOut !== dat[i-1]) begin
                    n_errors++;
                    $display("FAIL b2b_write[%0d] got w%b a%h d%h want 1 %h %h", i-1,
                             bif.write, bif.address, bif.dataOut,
                             cell_addr(idx[i-1]), dat[i-1]);
                end
            end
            if (i == 10) begin
                n_checks++;
                if (bif.write !== 1'b0 || bif.busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_done got w%b busy%b want 0 0", bif.write, bif.busy);
                end
            end
        end
    endtask

    task automatic test_present();
        int  reads = 0;
        bit  seen  = 1'b0;
        hang = 1'b0;
        lat  = 5;
        bif.color = 12'hFFF;
        bif.mode  = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            next_cycle();
            bif.presentReq = (i == 0);
            @(negedge clock);
            seen = bif.write;
        end
        n_checks++;
        if (!seen || bif.address !== 64'h0200_0000_0000_0000 ||
            bif.dataOut !== 64'h7FFD) begin
            n_errors++;
            $display("FAIL present_ctrl got seen%b a%h d%h want 1 0200000000000000 7ffd",
                     seen, bif.address, bif.dataOut);
        end
        for (int i = 0; i < 50; i++) begin
            next_cycle();
            @(negedge clock);
            if (!bif.read) break;
            reads++;
        end
        n_checks++;
        if (reads != 5) begin
            n_errors++;
            $display("FAIL present_reads got %0d want 5", reads);
        end
        n_checks++;
        if (bif.busy !== 1'b0 || bif.write !== 1'b0) begin
            n_errors++;
            $display("FAIL present_idle got busy%b w%b want 0 0", bif.busy, bif.write);
        end
    endtask

    task automatic test_clear_present();
        logic [63:0] wq[$];
        int reads = 0;
        bit done  = 1'b0;
        lat = 3;
        bif.color = 12'h123;
        bif.mode  = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            next_cycle();
            bif.presentReq = (i == 0);
            bif.clearReq   = (i == 0);
            @(negedge clock);
            if (bif.read && bif.write) begin
                n_checks++;
                n_errors++;
                $display("FAIL clrpre_exclusive got r1 w1 want never both");
            end
            if (bif.write) wq.push_back(bif.dataOut);
            if (bif.read) reads++;
            done = (wq.size() >= 2) && !bif.busy;
        end
        n_checks++;
        if (!done || wq.size() != 2) begin
            n_errors++;
            $display("FAIL clrpre_count got %0d writes done%b want 2 1", wq.size(), done);
        end else begin
            n_checks++;
            if (wq[0] !== ctrl_word(12'h123, 1'b0, 2'b10) ||
                wq[1] !== ctrl_word(12'h123, 1'b0, 2'b01)) begin
                n_errors++;
                $display("FAIL clrpre_order got %h %h want %h %h", wq[0], wq[1],
                         ctrl_word(12'h123, 1'b0, 2'b10), ctrl_word(12'h123, 1'b0, 2'b01));
            end
        end
        n_checks++;
        if (reads != 6) begin
            n_errors++;
            $display("FAIL clrpre_reads got %0d want 6", reads);
        end
    endtask

    task automatic test_bad_index();
        int strobes = 0;
        next_cycle();
        bif.charValid = 1'b1;
        bif.charIndex = 11'd1200;
        bif.charData  = 64'hDEAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            next_cycle();
            bif.charValid = 1'b0;
            if (bif.write || bif.read) strobes++;
        end
        @(negedge clock);
        n_checks++;
        if (strobes != 0) begin
            n_errors++;
            $display("FAIL badidx_bus got %0d strobes want 0", strobes);
        end
        n_checks++;
        if (bif.errors !== 2'b01 || bif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL badidx_err got err%b busy%b want 01 0", bif.errors, bif.busy);
        end
    endtask

    task automatic test_timeout_queue();
        logic [10:0] qi[$];
        logic [63:0] qd[$];
        int  reads = 0;
        int  early = 0;
        int  wr = 0;
        bit  seen = 1'b0;
        bit  ended = 1'b0;
        hang = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            next_cycle();
            bif.presentReq = (i == 0);
            @(negedge clock);
            seen = bif.write;
        end
        for (int i = 0; i < 5000 && !ended; i++) begin
            next_cycle();
            bif.charValid = (i < 10);
            bif.charIndex = 11'($urandom_range(0, 1199));
            bif.charData  = {$urandom, $urandom};
            @(negedge clock);
            if (i == 8) begin
                n_checks++;
                if (bif.charReady !== 1'b0) begin
                    n_errors++;
                    $display("FAIL timeout_full got rdy%b want 0", bif.charReady);
                end
            end
            if (bif.write) early++;
            if (bif.charValid && bif.charReady) begin
                qi.push_back(bif.charIndex);
                qd.push_back(bif.charData);
            end
            if (bif.read) reads++;
            else ended = (i > 0);
        end
        bif.charValid = 1'b0;
        n_checks++;
        if (!seen || reads != 4096 || early != 0) begin
            n_errors++;
            $display("FAIL timeout_reads got seen%b reads%0d early%0d want 1 4096 0",
                     seen, reads, early);
        end
        n_checks++;
        if (bif.errors !== 2'b11 || qi.size() != 8) begin
            n_errors++;
            $display("FAIL timeout_err got err%b queued%0d want 11 8", bif.errors, qi.size());
        end
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            @(negedge clock);
            if (bif.write) begin
                wr++;
                n_checks++;
                if (qi.size() == 0 || bif.address !== cell_addr(qi[0]) ||
                    bif.dataOut !== qd[0]) begin
                    n_errors++;
                    $display("FAIL timeout_drain got a%h d%h want queued entry",
                             bif.address, bif.dataOut);
                end
                if (qi.size() > 0) begin
                    void'(qi.pop_front());
                    void'(qd.pop_front());
                end
            end
        end
        n_checks++;
        if (wr != 8) begin
            n_errors++;
            $display("FAIL timeout_drain_count got %0d want 8", wr);
        end
        hang = 1'b0;
    endtask

    task automatic test_reset_poll();
        int strobes = 0;
        hang = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            bif.presentReq = (i == 0);
            bif.charValid  = (i == 4 || i == 5);
            bif.charIndex  = 11'd7;
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (bif.read !== 1'b1) begin
            n_errors++;
            $display("FAIL rstpoll_inpoll got r%b want 1", bif.read);
        end
        resetN = 1'b0;
        #1;
        n_checks++;
        if (bif.read !== 1'b0 || bif.write !== 1'b0 || bif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rstpoll_now got r%b w%b busy%b want 0 0 0",
                     bif.read, bif.write, bif.busy);
        end
        n_checks++;
        if (bif.charReady !== 1'b1 || bif.errors !== 2'b00) begin
            n_errors++;
            $display("FAIL rstpoll_state got rdy%b err%b want 1 00", bif.charReady, bif.errors);
        end
        hang = 1'b0;
        next_cycle();
        resetN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clock);
            if (bif.write || bif.read || bif.busy) strobes++;
        end
        n_checks++;
        if (strobes != 0) begin
            n_errors++;
            $display("FAIL rstpoll_empty got %0d active cycles want 0", strobes);
        end
    endtask

    task automatic test_random();
        logic [10:0] qi[$];
        logic [63:0] qd[$];
        logic [11:0] col;
        logic        md;
        bit in_poll = 1'b0;
        bit bad     = 1'b0;
        bit done    = 1'b0;
        col = 12'($urandom);
        md  = 1'($urandom);
        bif.color = col;
        bif.mode  = md;
        for (int c = 0; c < 1400 && !done; c++) begin
            next_cycle();
            lat = $urandom_range(1, 6);
            if (c < 800) begin
                bif.presentReq = ($urandom_range(0, 49) == 0);
                bif.charValid  = ($urandom_range(0, 9) < 6);
                bif.charIndex  = ($urandom_range(0, 19) == 0) ?
                                 11'($urandom_range(1200, 2047)) :
                                 11'($urandom_range(0, 1199));
                bif.charData   = {$urandom, $urandom};
            end else begin
                idle_inputs();
            end
            @(negedge clock);
            if (bif.read && bif.write) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand_exclusive at %0d got r1 w1", c);
            end
            if (bif.write && bif.address[10:0] >= 11'd4) begin
                n_checks++;
                if (in_poll || qi.size() == 0 || bif.address !== cell_addr(qi[0]) ||
                    bif.dataOut !== qd[0]) begin
                    n_errors++;
                    $display("FAIL rand_char at %0d got a%h d%h poll%b want %h %h", c,
                             bif.address, bif.dataOut, in_poll,
                             qi.size() ? cell_addr(qi[0]) : 64'h0,
                             qd.size() ? qd[0] : 64'h0);
                end
                if (qi.size() > 0) begin
                    void'(qi.pop_front());
                    void'(qd.pop_front());
                end
            end else if (bif.write) begin
                n_checks++;
                if (bif.address !== 64'h0200_0000_0000_0000 ||
                    bif.dataOut !== ctrl_word(col, md, 2'b01)) begin
                    n_errors++;
                    $display("FAIL rand_ctrl at %0d got a%h d%h want 0200000000000000 %h",
                             c, bif.address, bif.dataOut, ctrl_word(col, md, 2'b01));
                end
                in_poll = 1'b1;
            end else if (!bif.read) begin
                in_poll = 1'b0;
            end
            if (bif.charValid && bif.charReady) begin
                if (bif.charIndex < 11'd1200) begin
                    qi.push_back(bif.charIndex);
                    qd.push_back(bif.charData);
                end else begin
                    bad = 1'b1;
                end
            end
            done = (c >= 800) && !bif.busy;
        end
        n_checks++;
        if (!done || qi.size() != 0) begin
            n_errors++;
            $display("FAIL rand_drain got done%b left%0d want 1 0", done, qi.size());
        end
        n_checks++;
        if (bif.errors[0] !== bad) begin
            n_errors++;
            $display("FAIL rand_err0 got %b want %b", bif.errors[0], bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_back_to_back();
        test_present();
        test_clear_present();
        test_bad_index();
        test_timeout_queue();
        test_reset_poll();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
